// File: rtl/button_pkg.sv
// Shared definitions for the two-channel push-button debouncer.
// Holds the per-channel FSM encoding and the default timing constants.
package button_pkg;

   typedef enum logic [1:0] {
      StReleased       = 2'd0,
      StConfirmPress   = 2'd1,
      StHeld           = 2'd2,
      StConfirmRelease = 2'd3
   } deb_state_e;

   // 10 ms at 50 MHz
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/debounce_channel.sv
// One debounced push-button: synchronizer, confirm FSM with stability counter,
// registered level output and one-cycle press/release pulses.
module debounce_channel
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic button,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   deb_state_e             state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   button_q, press_q, release_q;

   // Reset value 1 models a released (active-low) key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
      end
   end

   assign synced = ~sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         StReleased: begin
            if (synced) begin
               state_d = StConfirmPress;
               cnt_d   = CntOne;
            end
         end
         StConfirmPress: begin
            if (!synced) begin
               state_d = StReleased;
            end else if (cnt_q == CntLast) begin
               state_d = StHeld;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StHeld: begin
            if (!synced) begin
               state_d = StConfirmRelease;
               cnt_d   = CntOne;
            end
         end
         StConfirmRelease: begin
            if (synced) begin
               state_d = StHeld;
            end else if (cnt_q == CntLast) begin
               state_d = StReleased;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: begin
            state_d = StReleased;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StReleased;
         cnt_q     <= '0;
         button_q  <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         // Outputs registered from the next state so they line up with state_q.
         button_q  <= (state_d == StHeld) || (state_d == StConfirmRelease);
         press_q   <= (state_q == StConfirmPress) && (state_d == StHeld);
         release_q <= (state_q == StConfirmRelease) && (state_d == StReleased);
      end
   end

   assign button        = button_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Two independent debounced push-buttons; wiring only, the logic lives in
// debounce_channel.
module button_debouncer
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key1_n,
   input  logic key2_n,
   output logic button1,
   output logic button2,
   output logic press1,
   output logic press2,
   output logic release1,
   output logic release2
);

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_ch1 (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_n         (key1_n),
      .button        (button1),
      .press_pulse   (press1),
      .release_pulse (release1)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_ch2 (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_n         (key2_n),
      .button        (button2),
      .press_pulse   (press2),
      .release_pulse (release2)
   );

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2;
// expected edges are 6 clocks after a clean key change.
module tb_button_debouncer;

   logic clk;
   logic rst_n;
   logic key1_n, key2_n;
   logic button1, button2, press1, press2, release1, release2;

   int n_total = 0;
   int n_bad   = 0;
   int p1, p2, r1, r2, overlap;

   button_debouncer #(
      .DEBOUNCE_CYCLES (4),
      .SYNC_STAGES     (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key1_n   (key1_n),
      .key2_n   (key2_n),
      .button1  (button1),
      .button2  (button2),
      .press1   (press1),
      .press2   (press2),
      .release1 (release1),
      .release2 (release2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock; sample 1 ns after the rising edge and tally pulses.
   task automatic tick();
      @(posedge clk);
      #1;
      p1 += int'(press1);
      p2 += int'(press2);
      r1 += int'(release1);
      r2 += int'(release2);
      if ((press1 && release1) || (press2 && release2)) overlap++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear();
      p1 = 0; p2 = 0; r1 = 0; r2 = 0;
   endtask

   function automatic logic [5:0] outs();
      return {button1, button2, press1, press2, release1, release2};
   endfunction

   initial begin
      overlap = 0;
      clear();
      rst_n  = 1'b0;
      key1_n = 1'b1;
      key2_n = 1'b1;
      run(3);
      check("reset_outs", 32'(outs()), 32'd0);
      rst_n = 1'b1;
      run(5);
      check("idle_outs", 32'(outs()), 32'd0);

      // Clean press/release on channel 1.
      clear();
      key1_n = 1'b0;
      run(5);
      check("clean_b1_early", 32'(button1), 32'd0);
      tick();
      check("clean_b1_rise", 32'(button1), 32'd1);
      check("clean_press1", 32'(press1), 32'd1);
      tick();
      check("clean_press1_1cyc", 32'(press1), 32'd0);
      run(12);
      check("clean_b1_held", 32'(button1), 32'd1);
      check("clean_press1_cnt", 32'(p1), 32'd1);
      check("clean_b2_idle", 32'(button2), 32'd0);
      check("clean_press2_cnt", 32'(p2), 32'd0);
      key1_n = 1'b1;
      run(5);
      check("clean_b1_still", 32'(button1), 32'd1);
      tick();
      check("clean_release1", 32'(release1), 32'd1);
      check("clean_b1_fall", 32'(button1), 32'd0);
      run(4);
      check("clean_release1_cnt", 32'(r1), 32'd1);

      // Bounce: 0/1 every 2 cycles for 16 cycles, then settle low.
      clear();
      for (int seg = 0; seg < 8; seg++) begin
         key1_n = (seg % 2 == 1);
         run(2);
      end
      key1_n = 1'b0;
      check("bounce_no_press", 32'(p1), 32'd0);
      check("bounce_b1_low", 32'(button1), 32'd0);
      run(5);
      check("bounce_b1_early", 32'(button1), 32'd0);
      tick();
      check("bounce_press1", 32'(press1), 32'd1);
      run(10);
      check("bounce_press1_cnt", 32'(p1), 32'd1);
      key1_n = 1'b1;
      run(12);
      check("bounce_b1_released", 32'(button1), 32'd0);

      // Glitch rejection on channel 2, released then held.
      clear();
      key2_n = 1'b0;
      run(3);
      key2_n = 1'b1;
      run(10);
      check("glitch_b2_low", 32'(button2), 32'd0);
      check("glitch_no_press2", 32'(p2), 32'd0);
      key2_n = 1'b0;
      run(10);
      check("glitch_b2_pressed", 32'(button2), 32'd1);
      check("glitch_press2_cnt", 32'(p2), 32'd1);
      clear();
      key2_n = 1'b1;
      run(3);
      key2_n = 1'b0;
      run(10);
      check("glitch_b2_held", 32'(button2), 32'd1);
      check("glitch_no_release2", 32'(r2), 32'd0);
      key2_n = 1'b1;
      run(10);
      check("glitch_release2_cnt", 32'(r2), 32'd1);
      check("glitch_b1_untouched", 32'(button1), 32'd0);

      // Simultaneous press and release.
      clear();
      key1_n = 1'b0;
      key2_n = 1'b0;
      run(6);
      check("simul_press", 32'({press1, press2}), 32'd3);
      run(24);
      key1_n = 1'b1;
      key2_n = 1'b1;
      run(6);
      check("simul_release", 32'({release1, release2}), 32'd3);
      run(4);
      check("simul_counts", 32'({p1[7:0], p2[7:0], r1[7:0], r2[7:0]}), 32'h01010101);

      // Reset during confirm-press at count 2.
      clear();
      key1_n = 1'b0;
      run(4);
      rst_n = 1'b0;
      #1;
      check("rstmid_outs", 32'(outs()), 32'd0);
      run(2);
      check("rstmid_outs_hold", 32'(outs()), 32'd0);
      check("rstmid_no_press", 32'(p1), 32'd0);
      rst_n = 1'b1;
      run(5);
      check("rstmid_b1_early", 32'(button1), 32'd0);
      tick();
      check("rstmid_press1", 32'({button1, press1}), 32'd3);
      run(5);
      check("rstmid_press1_cnt", 32'(p1), 32'd1);

      // Reset while held with key still down.
      clear();
      rst_n = 1'b0;
      #1;
      check("rsthold_b1_drop", 32'(button1), 32'd0);
      run(3);
      check("rsthold_outs", 32'(outs()), 32'd0);
      rst_n = 1'b1;
      run(5);
      check("rsthold_b1_early", 32'(button1), 32'd0);
      tick();
      check("rsthold_press1", 32'({button1, press1}), 32'd3);
      run(5);
      check("rsthold_press1_cnt", 32'(p1), 32'd1);
      check("rsthold_no_release", 32'(r1), 32'd0);
      key1_n = 1'b1;
      run(10);
      check("rsthold_b1_released", 32'(button1), 32'd0);

      check("pulse_overlap", 32'(overlap), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, means consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter SYNC_STAGES, default 2, means synchronizer flop depth per channel; legal range 2..3.
REQ-003 Port clk, input, 1, is the single system clock; all flops SHALL be clocked on its rising edge.
REQ-004 Port rst_n, input, 1, is the asynchronous active-low reset.
REQ-005 Port key1_n, input, 1, is raw push-button 1 (active-low, bouncing, asynchronous to clk).
REQ-006 Port key2_n, input, 1, is raw push-button 2 (active-low, bouncing, asynchronous to clk).
REQ-007 Port button1, output, 1, is debounced active-high level of key1_n, directly usable as a button1 level input.
REQ-008 Port button2, output, 1, is debounced active-high level of key2_n.
REQ-009 Port press1/press2, output, 1 each, is a one-cycle pulse on accepted press of channel 1/2.
REQ-010 Port release1/release2, output, 1 each, is a one-cycle pulse on accepted release of channel 1/2.

Function
REQ-011 Each channel SHALL pass its raw key through SYNC_STAGES flops, then invert to active-high, before any other logic.
REQ-012 Each channel SHALL run a 4-state FSM: RELEASED, CONFIRM_PRESS, HELD, CONFIRM_RELEASE.
REQ-013 RELEASED: synced=1 -> CONFIRM_PRESS, counter loads 1; else stay, counter 0.
REQ-014 CONFIRM_PRESS: synced=1 and counter=DEBOUNCE_CYCLES-1 -> HELD; synced=1 otherwise -> counter+1; synced=0 -> RELEASED, counter 0.
REQ-015 HELD: synced=0 -> CONFIRM_RELEASE, counter loads 1; else stay, counter 0.
REQ-016 CONFIRM_RELEASE: synced=0 and counter=DEBOUNCE_CYCLES-1 -> RELEASED; synced=0 otherwise -> counter+1; synced=1 -> HELD, counter 0.
REQ-017 Button level output SHALL be 1 exactly in HELD and CONFIRM_RELEASE, registered (no combinational path from key input).
REQ-018 Press pulse SHALL be high for exactly one cycle, the first cycle the FSM is in HELD after CONFIRM_PRESS; release pulse likewise on entry to RELEASED from CONFIRM_RELEASE.
REQ-019 Latency from raw edge (bounce-free) to level output change SHALL be SYNC_STAGES+DEBOUNCE_CYCLES cycles, ±1 for metastability resolution.
REQ-020 Any opposite-level sample during confirmation SHALL restart confirmation from zero; glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change and no pulse.
REQ-021 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); counter SHALL never wrap or exceed DEBOUNCE_CYCLES-1.
REQ-022 Channels SHALL be fully independent; simultaneous presses SHALL yield simultaneous, independent pulses.
REQ-023 Press and release pulses of one channel SHALL never be high in the same cycle.

Reset
REQ-024 While rst_n=0: sync flops SHALL hold 1 (released), FSMs RELEASED, counters 0, all outputs 0.
REQ-025 Reset assertion SHALL take effect immediately; deassertion SHALL be synchronized by the system reset bridge external to this block.
REQ-026 Key held pressed through reset release SHALL be accepted as a press (level 1 plus one press pulse) after REQ-019 latency.
REQ-027 Reset mid-confirmation SHALL discard the partial count; no pulse SHALL be emitted for the aborted transition.

Structure
REQ-028 Shared package button_pkg SHALL hold the FSM state encoding (2-bit: RELEASED=0, CONFIRM_PRESS=1, HELD=2, CONFIRM_RELEASE=3) and the default DEBOUNCE_CYCLES constant.
REQ-029 One sub-module, debounce_channel (sync + FSM + counter, one key), SHALL be instantiated twice; the top SHALL contain only instantiation and wiring.

Verification (bench runs DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-030 Clean press: key1_n 1->0 held 20 cycles -> button1 rises 6 cycles later (±1), press1 high exactly 1 cycle, button2/press2 stay 0.
REQ-031 Bounce: key1_n toggles 0/1 every 2 cycles for 16 cycles then holds 0 -> no pulse during bounce; single press1 6 cycles after final edge.
REQ-032 Glitch reject: key2_n low for 3 cycles while released -> button2 stays 0, press2 never asserts; same 3-cycle high glitch while held -> no release2.
REQ-033 Simultaneous: key1_n and key2_n fall same cycle, rise 30 cycles later -> press1/press2 same cycle, release1/release2 same cycle.
REQ-034 Reset mid-op: rst_n low 2 cycles during CONFIRM_PRESS count 2 -> all outputs 0 immediately; key still low -> press1 6 cycles after rst_n high.
REQ-035 Reset with key held: key1_n=0 throughout reset -> button1=0 in reset, then 1 with one press1 after latency.
